// File: rtl/aoi_seq_eval_if.sv
// Term-beat input stream and result output stream of the sequential AOI evaluator.
// The master drives term beats and accepts results; the slave is the evaluator.
interface aoi_seq_eval_if #(
    parameter int TERM_W    = 3,
    parameter int MAX_TERMS = 8
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    logic              in_valid;
    logic              in_ready;
    logic [TERM_W-1:0] in_lits;
    logic [TERM_W-1:0] in_mask;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic              out_f;
    logic [CNT_W-1:0]  out_nterms;
    logic              out_err;

    modport master (
        output in_valid, in_lits, in_mask, in_last, out_ready,
        input  in_ready, out_valid, out_f, out_nterms, out_err
    );

    modport slave (
        input  in_valid, in_lits, in_mask, in_last, out_ready,
        output in_ready, out_valid, out_f, out_nterms, out_err
    );
endinterface

// File: rtl/aoi_seq_eval.sv
// Sequential AND-OR-(INVERT) evaluator: ORs one masked product term per accepted beat
// and presents the (optionally inverted) sum with its term count and an overflow flag.
module aoi_seq_eval #(
    parameter int TERM_W    = 3,
    parameter int MAX_TERMS = 8,
    parameter int INVERT    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    aoi_seq_eval_if.slave       bus
);
    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic              r_acc;
    logic [CNT_W-1:0]  r_count;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_out_f;
    logic [CNT_W-1:0]  r_out_nterms;
    logic              r_out_err;

    logic [TERM_W-1:0] w_lits_eff;
    logic              w_accept;
    logic              w_p;
    logic              w_acc_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_close;

    function automatic logic polarity(input logic v);
        return (INVERT != 0) ? ~v : v;
    endfunction

    // Masked-out literals are forced to 1 so they drop out of the AND.
    assign w_lits_eff = bus.in_lits | ~bus.in_mask;
    assign w_p        = &w_lits_eff;
    assign w_accept   = bus.in_valid & r_in_ready;
    assign w_acc_nxt  = r_acc | w_p;
    assign w_cnt_nxt  = r_count + CNT_W'(1);
    assign w_close    = bus.in_last | (w_cnt_nxt == CNT_W'(MAX_TERMS));

    // in_ready is registered so it stays low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_acc        <= 1'b0;
            r_count      <= '0;
            r_in_ready   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_f      <= polarity(1'b0);
            r_out_nterms <= '0;
            r_out_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_acc   <= w_acc_nxt;
                        r_count <= w_cnt_nxt;
                        if (w_close) begin
                            r_state      <= S_DONE;
                            r_in_ready   <= 1'b0;
                            r_out_valid  <= 1'b1;
                            r_out_f      <= polarity(w_acc_nxt);
                            r_out_nterms <= w_cnt_nxt;
                            r_out_err    <= ~bus.in_last;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_DONE: begin
                    // Result handshake: no beat can be taken on this edge, giving one bubble.
                    if (bus.out_ready) begin
                        r_state     <= S_IDLE;
                        r_acc       <= 1'b0;
                        r_count     <= '0;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_err   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_acc       <= 1'b0;
                    r_count     <= '0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_err   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_f      = r_out_f;
    assign bus.out_nterms = r_out_nterms;
    assign bus.out_err    = r_out_err;
endmodule

// File: tb/tb_aoi_seq_eval.sv
// Bench for aoi_seq_eval: vector table, hand-written multi-cycle sequences and a
// randomized beat stream against a behavioural sum-of-products model (AOI and AO builds).
module tb_aoi_seq_eval;
    localparam int TERM_W    = 3;
    localparam int MAX_TERMS = 8;
    localparam int CNT_W     = $clog2(MAX_TERMS + 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aoi_seq_eval_if #(.TERM_W(TERM_W), .MAX_TERMS(MAX_TERMS)) bus0 ();
    aoi_seq_eval_if #(.TERM_W(TERM_W), .MAX_TERMS(MAX_TERMS)) bus1 ();

    aoi_seq_eval #(.TERM_W(TERM_W), .MAX_TERMS(MAX_TERMS), .INVERT(1)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    aoi_seq_eval #(.TERM_W(TERM_W), .MAX_TERMS(MAX_TERMS), .INVERT(0)) dut_ao (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_lits   = bus0.in_lits;
    assign bus1.in_mask   = bus0.in_mask;
    assign bus1.in_last   = bus0.in_last;
    assign bus1.out_ready = bus0.out_ready;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        logic f;
        int   n;
        logic err;
    } res_t;

    res_t exp_q[$];
    int   m_n   = 0;
    logic m_any = 1'b0;

    function automatic logic term_val(input logic [TERM_W-1:0] l, input logic [TERM_W-1:0] m);
        logic p;
        p = 1'b1;
        for (int i = 0; i < TERM_W; i++)
            if (m[i] && !l[i]) p = 1'b0;
        return p;
    endfunction

    task automatic model_beat(input logic [TERM_W-1:0] l, input logic [TERM_W-1:0] m, input logic last);
        res_t r;
        m_n++;
        m_any = m_any | term_val(l, m);
        if (last || m_n == MAX_TERMS) begin
            r.f   = !m_any;
            r.n   = m_n;
            r.err = !last;
            exp_q.push_back(r);
            m_n   = 0;
            m_any = 1'b0;
        end
    endtask

    // ---------------- stimulus helpers (entered and left at a negedge) ----------------
    task automatic send_beat(input logic [TERM_W-1:0] l, input logic [TERM_W-1:0] m, input logic last);
        int w;
        w = 0;
        bus0.in_valid = 1'b1;
        bus0.in_lits  = l;
        bus0.in_mask  = m;
        bus0.in_last  = last;
        while (!bus0.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!bus0.in_ready) begin
            check("send_ready_timeout", {31'b0, bus0.in_ready}, 1);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        bus0.in_valid = 1'b0;
        bus0.in_lits  = TERM_W'($urandom);
        bus0.in_mask  = TERM_W'($urandom);
        bus0.in_last  = 1'($urandom);
    endtask

    task automatic get_result(input logic ef, input int en, input logic eerr, input string name, input int hold);
        int w;
        w = 0;
        while (!bus0.out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({name, "_valid"}, {31'b0, bus0.out_valid}, 1);
        check({name, "_f"}, {31'b0, bus0.out_f}, {31'b0, ef});
        check({name, "_nterms"}, 32'(bus0.out_nterms), 32'(en));
        check({name, "_err"}, {31'b0, bus0.out_err}, {31'b0, eerr});
        check({name, "_ao_f"}, {31'b0, bus1.out_f}, {31'b0, !ef});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, "_hold_valid"}, {31'b0, bus0.out_valid}, 1);
            check({name, "_hold_f"}, {31'b0, bus0.out_f}, {31'b0, ef});
            check({name, "_hold_nterms"}, 32'(bus0.out_nterms), 32'(en));
            check({name, "_hold_rdy"}, {31'b0, bus0.in_ready}, 0);
        end
        bus0.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus0.out_ready = 1'b0;
        check({name, "_post_valid"}, {31'b0, bus0.out_valid}, 0);
        check({name, "_post_err"}, {31'b0, bus0.out_err}, 0);
        check({name, "_post_rdy"}, {31'b0, bus0.in_ready}, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string                         name;
        int                            nb;
        logic [2:0][TERM_W-1:0]        l;
        logic [2:0][TERM_W-1:0]        m;
        logic                          f;
        int                            n;
    } vec_t;

    function automatic vec_t mk(input string name, input int nb,
                                input logic [TERM_W-1:0] l0, input logic [TERM_W-1:0] m0,
                                input logic [TERM_W-1:0] l1, input logic [TERM_W-1:0] m1,
                                input logic [TERM_W-1:0] l2, input logic [TERM_W-1:0] m2,
                                input logic f, input int n);
        vec_t v;
        v.name = name; v.nb = nb;
        v.l[0] = l0; v.m[0] = m0;
        v.l[1] = l1; v.m[1] = m1;
        v.l[2] = l2; v.m[2] = m2;
        v.f = f; v.n = n;
        return v;
    endfunction

    vec_t tbl[7];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t r;
        logic [TERM_W-1:0] rl, rm;
        logic rlast;

        tbl[0] = mk("t1_ab_cde",   2, 3'b011, 3'b011, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0, 2);
        tbl[1] = mk("t2_cde_true", 2, 3'b001, 3'b011, 3'b111, 3'b111, 3'b000, 3'b000, 1'b0, 2);
        tbl[2] = mk("t2_none",     2, 3'b000, 3'b011, 3'b011, 3'b111, 3'b000, 3'b000, 1'b1, 2);
        tbl[3] = mk("t3_empty",    1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1);
        tbl[4] = mk("three_zero",  3, 3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 1'b1, 3);
        tbl[5] = mk("masked_hit",  1, 3'b101, 3'b101, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0, 1);
        tbl[6] = mk("partial_miss",1, 3'b110, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1);

        rst_n          = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_lits   = '0;
        bus0.in_mask   = '0;
        bus0.in_last   = 1'b0;
        bus0.out_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_valid",  {31'b0, bus0.out_valid}, 0);
        check("rst_rdy",    {31'b0, bus0.in_ready}, 0);
        check("rst_f",      {31'b0, bus0.out_f}, 1);
        check("rst_ao_f",   {31'b0, bus1.out_f}, 0);
        check("rst_nterms", 32'(bus0.out_nterms), 0);
        check("rst_err",    {31'b0, bus0.out_err}, 0);
        rst_n = 1'b1;
        #1;
        check("rdy_before_edge", {31'b0, bus0.in_ready}, 0);
        @(negedge clk);
        check("rdy_after_edge", {31'b0, bus0.in_ready}, 1);

        for (int t = 0; t < 7; t++) begin
            for (int b = 0; b < tbl[t].nb; b++)
                send_beat(tbl[t].l[b], tbl[t].m[b], b == tbl[t].nb - 1);
            check({tbl[t].name, "_latency"}, {31'b0, bus0.out_valid}, 1);
            get_result(tbl[t].f, tbl[t].n, 1'b0, tbl[t].name, 0);
        end

        // Stalled consumer: result must hold for 5 cycles with input blocked.
        send_beat(3'b011, 3'b011, 1'b0);
        send_beat(3'b000, 3'b111, 1'b1);
        get_result(1'b0, 2, 1'b0, "stall5", 5);

        // Overflow: eight non-last beats, ninth waits for the handshake then starts fresh.
        for (int b = 0; b < MAX_TERMS; b++) begin
            check("ovf_rdy_before", {31'b0, bus0.in_ready}, 1);
            send_beat(3'b000, 3'b111, 1'b0);
        end
        check("ovf_latency", {31'b0, bus0.out_valid}, 1);
        bus0.in_valid = 1'b1;
        bus0.in_lits  = 3'b111;
        bus0.in_mask  = 3'b111;
        bus0.in_last  = 1'b1;
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check("ovf_blocked_rdy", {31'b0, bus0.in_ready}, 0);
            check("ovf_blocked_nterms", 32'(bus0.out_nterms), 8);
        end
        get_result(1'b1, 8, 1'b1, "ovf", 0);
        @(posedge clk);
        @(negedge clk);
        bus0.in_valid = 1'b0;
        check("after_ovf_latency", {31'b0, bus0.out_valid}, 1);
        get_result(1'b0, 1, 1'b0, "after_ovf", 0);

        // Last on the MAX_TERMS-th beat is not an overflow.
        for (int b = 0; b < MAX_TERMS; b++)
            send_beat(3'b000, 3'b111, b == MAX_TERMS - 1);
        get_result(1'b1, 8, 1'b0, "max_last", 0);

        // Reset in the middle of a three-beat expression.
        send_beat(3'b111, 3'b111, 1'b0);
        send_beat(3'b000, 3'b111, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid",  {31'b0, bus0.out_valid}, 0);
        check("midrst_rdy",    {31'b0, bus0.in_ready}, 0);
        check("midrst_ao_rdy", {31'b0, bus1.in_ready}, 0);
        check("midrst_f",      {31'b0, bus0.out_f}, 1);
        check("midrst_nterms", 32'(bus0.out_nterms), 0);
        check("midrst_err",    {31'b0, bus0.out_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_rdy_up", {31'b0, bus0.in_ready}, 1);
        send_beat(3'b111, 3'b111, 1'b1);
        get_result(1'b0, 1, 1'b0, "post_rst", 0);

        // Reset while a result is held.
        send_beat(3'b000, 3'b111, 1'b1);
        check("donerst_pre_valid", {31'b0, bus0.out_valid}, 1);
        rst_n = 1'b0;
        #1;
        check("donerst_valid", {31'b0, bus0.out_valid}, 0);
        check("donerst_nterms", 32'(bus0.out_nterms), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Randomized stream against the model.
        m_n   = 0;
        m_any = 1'b0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            rl    = TERM_W'($urandom);
            rm    = TERM_W'($urandom);
            rlast = (i == 299) ? 1'b1 : ($urandom_range(0, 3) == 0);
            model_beat(rl, rm, rlast);
            send_beat(rl, rm, rlast);
            if (exp_q.size() > 0) begin
                r = exp_q.pop_front();
                get_result(r.f, r.n, r.err, "rand", $urandom_range(0, 2));
            end
        end
        check("rand_queue_empty", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
